// File: rtl/msrv32_pkg.sv
// rtl/msrv32_pkg.sv - shared immediate-type codes and skid-buffer state encoding
// Purpose: constants shared by the immediate decoder and the pipelined wrapper.
// Ports:   none (package).
package msrv32_pkg;

  localparam logic [3:0] IMM_I     = 4'd0;
  localparam logic [3:0] IMM_I_ALT = 4'd1;
  localparam logic [3:0] IMM_S     = 4'd2;
  localparam logic [3:0] IMM_B     = 4'd3;
  localparam logic [3:0] IMM_U     = 4'd4;
  localparam logic [3:0] IMM_J     = 4'd5;
  localparam logic [3:0] IMM_CSR   = 4'd6;
  localparam logic [3:0] IMM_I2    = 4'd7;
  localparam logic [3:0] IMM_CI    = 4'd8;
  localparam logic [3:0] IMM_CLS   = 4'd9;
  localparam logic [3:0] IMM_CJ    = 4'd10;
  localparam logic [3:0] IMM_CB    = 4'd11;

  // EMPTY: nothing held; ONE: output register full; TWO: output and skid full.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } buf_state_t;

endpackage

// File: rtl/msrv32_imm_decode_comb.sv
// rtl/msrv32_imm_decode_comb.sv - combinational immediate extraction for RV base and RVC formats
// Purpose: maps (instr, imm_type) to an XLEN-wide immediate plus an illegal-type flag.
// Ports:   instr    - raw instruction (RVC formats use bits [15:0])
//          imm_type - immediate type select
//          imm      - sign/zero-extended immediate
//          illegal  - imm_type not supported (imm then carries the I-type value)
module msrv32_imm_decode_comb
  import msrv32_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int RVC_EN = 1
) (
  input  logic [31:0]     instr,
  input  logic [3:0]      imm_type,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  logic [31:0] i_val;
  logic [31:0] val;
  logic        unused_bits;

  // Opcode size bits never feed an immediate.
  assign unused_bits = ^instr[1:0];

  assign i_val = {{20{instr[31]}}, instr[31:20]};

  always_comb begin
    val     = i_val;
    illegal = 1'b0;
    case (imm_type)
      IMM_I, IMM_I_ALT, IMM_I2: val = i_val;
      IMM_S:   val = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   val = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   val = {instr[31:12], 12'h000};
      IMM_J:   val = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      IMM_CSR: val = {27'h0, instr[19:15]};
      IMM_CI, IMM_CLS, IMM_CJ, IMM_CB: begin
        if (RVC_EN != 0) begin
          case (imm_type)
            IMM_CI:  val = {{26{instr[12]}}, instr[12], instr[6:2]};
            IMM_CLS: val = {25'h0, instr[5], instr[12:10], instr[6], 2'b00};
            // offset[11|10|9:8|7|6|5|4|3:1] gathered in descending bit order.
            IMM_CJ:  val = {{20{instr[12]}}, instr[12], instr[8], instr[10:9], instr[6],
                            instr[7], instr[2], instr[11], instr[5:3], 1'b0};
            // offset[8|7:6|5|4:3|2:1] gathered in descending bit order.
            default: val = {{23{instr[12]}}, instr[12], instr[6:5], instr[2],
                            instr[11:10], instr[4:3], 1'b0};
          endcase
        end else begin
          illegal = 1'b1;
        end
      end
      default: illegal = 1'b1;
    endcase
  end

  // Every 32-bit value above is already correctly extended to bit 31, so a
  // signed widening gives the right XLEN result for both sext and zext cases.
  assign imm = XLEN'($signed(val));

endmodule

// File: rtl/msrv32_imm_gen_pipe.sv
// rtl/msrv32_imm_gen_pipe.sv - registered immediate generator with 2-entry skid buffer
// Purpose: decode-to-execute immediate stage; back-pressure is absorbed by a skid
//          register so ready_out depends on state only, never on ready_in.
// Ports:   clk_in, rst_n_in (async active-low), flush_in (sync clear)
//          valid_in/ready_out/instr_in/imm_type_in - upstream entry
//          valid_out/ready_in/imm_out/illegal_out  - downstream entry
module msrv32_imm_gen_pipe
  import msrv32_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int RVC_EN = 1
) (
  input  logic            clk_in,
  input  logic            rst_n_in,
  input  logic            flush_in,
  input  logic            valid_in,
  output logic            ready_out,
  input  logic [31:0]     instr_in,
  input  logic [3:0]      imm_type_in,
  output logic            valid_out,
  input  logic            ready_in,
  output logic [XLEN-1:0] imm_out,
  output logic            illegal_out
);

  buf_state_t      state, state_nxt;
  logic [XLEN-1:0] dec_imm, out_imm, skid_imm;
  logic            dec_ill, out_ill, skid_ill;
  logic            accept, drain;
  logic            load_out, load_skid, out_from_skid;

  msrv32_imm_decode_comb #(
    .XLEN   (XLEN),
    .RVC_EN (RVC_EN)
  ) u_decode (
    .instr    (instr_in),
    .imm_type (imm_type_in),
    .imm      (dec_imm),
    .illegal  (dec_ill)
  );

  assign valid_out   = (state != ST_EMPTY);
  assign ready_out   = (state != ST_TWO);
  assign imm_out     = out_imm;
  assign illegal_out = out_ill;

  assign accept = valid_in & ready_out;
  assign drain  = valid_out & ready_in;

  always_comb begin
    state_nxt     = state;
    load_out      = 1'b0;
    load_skid     = 1'b0;
    out_from_skid = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (accept) begin
          state_nxt = ST_ONE;
          load_out  = 1'b1;
        end
      end
      ST_ONE: begin
        if (accept && !drain) begin
          state_nxt = ST_TWO;
          load_skid = 1'b1;
        end else if (accept && drain) begin
          load_out  = 1'b1;
        end else if (drain) begin
          state_nxt = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (drain) begin
          state_nxt     = ST_ONE;
          out_from_skid = 1'b1;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
    // Flush beats any simultaneous accept or drain; data moves are suppressed
    // so nothing from the flushed cycle lingers in the registers.
    if (flush_in) begin
      state_nxt     = ST_EMPTY;
      load_out      = 1'b0;
      load_skid     = 1'b0;
      out_from_skid = 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state    <= ST_EMPTY;
      out_imm  <= '0;
      out_ill  <= 1'b0;
      skid_imm <= '0;
      skid_ill <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load_out) begin
        out_imm <= dec_imm;
        out_ill <= dec_ill;
      end else if (out_from_skid) begin
        out_imm <= skid_imm;
        out_ill <= skid_ill;
      end
      if (load_skid) begin
        skid_imm <= dec_imm;
        skid_ill <= dec_ill;
      end
    end
  end

endmodule

// File: tb/tb_msrv32_imm_gen_pipe.sv
// tb/tb_msrv32_imm_gen_pipe.sv - scoreboard bench for three configurations of the immediate pipe
module tb_msrv32_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n, flush, ready_in;
  logic [31:0] instr;
  logic [3:0]  imm_type;
  logic        vin0, vin1, vin2;
  logic        ro0, ro1, ro2, vo0, vo1, vo2, ill0, ill1, ill2;
  logic [31:0] imm0, imm2;
  logic [63:0] imm1;

  typedef struct packed {
    logic [63:0] imm;
    logic        ill;
  } exp_t;

  exp_t q0[$], q1[$], q2[$];
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // dut0: XLEN=32 RVC on; dut1: XLEN=64 RVC on; dut2: XLEN=32 RVC off
  msrv32_imm_gen_pipe #(.XLEN(32), .RVC_EN(1)) dut0 (
    .clk_in(clk), .rst_n_in(rst_n), .flush_in(flush), .valid_in(vin0), .ready_out(ro0),
    .instr_in(instr), .imm_type_in(imm_type), .valid_out(vo0), .ready_in(ready_in),
    .imm_out(imm0), .illegal_out(ill0));
  msrv32_imm_gen_pipe #(.XLEN(64), .RVC_EN(1)) dut1 (
    .clk_in(clk), .rst_n_in(rst_n), .flush_in(flush), .valid_in(vin1), .ready_out(ro1),
    .instr_in(instr), .imm_type_in(imm_type), .valid_out(vo1), .ready_in(ready_in),
    .imm_out(imm1), .illegal_out(ill1));
  msrv32_imm_gen_pipe #(.XLEN(32), .RVC_EN(0)) dut2 (
    .clk_in(clk), .rst_n_in(rst_n), .flush_in(flush), .valid_in(vin2), .ready_out(ro2),
    .instr_in(instr), .imm_type_in(imm_type), .valid_out(vo2), .ready_in(ready_in),
    .imm_out(imm2), .illegal_out(ill2));

  function automatic logic rdy(input int sel);
    return (sel == 0) ? ro0 : (sel == 1) ? ro1 : ro2;
  endfunction

  function automatic int qsize(input int sel);
    return (sel == 0) ? q0.size() : (sel == 1) ? q1.size() : q2.size();
  endfunction

  task automatic set_valid(input int sel, input logic v);
    if (sel == 0) vin0 = v;
    else if (sel == 1) vin1 = v;
    else vin2 = v;
  endtask

  task automatic cmp(input string name, input logic [63:0] got, input logic [63:0] req);
    vectors++;
    if (got !== req) begin
      miscompares++;
      $display("FAIL %s got=%h required=%h", name, got, req);
    end
  endtask

  task automatic check_out(input int sel, input logic [63:0] imm, input logic ill);
    exp_t e;
    bit   have;
    have = 1'b0;
    e    = '0;
    if (sel == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
    if (sel == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
    if (sel == 2 && q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
    vectors++;
    if (!have) begin
      miscompares++;
      $display("FAIL out%0d_unexpected got imm=%h ill=%b, required no output", sel, imm, ill);
    end else if (imm !== e.imm || ill !== e.ill) begin
      miscompares++;
      $display("FAIL out%0d_data got imm=%h ill=%b, required imm=%h ill=%b",
               sel, imm, ill, e.imm, e.ill);
    end
  endtask

  always @(negedge clk) if (rst_n && vo0 && ready_in) check_out(0, {32'h0, imm0}, ill0);
  always @(negedge clk) if (rst_n && vo1 && ready_in) check_out(1, imm1, ill1);
  always @(negedge clk) if (rst_n && vo2 && ready_in) check_out(2, {32'h0, imm2}, ill2);

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic issue(input int sel, input logic [31:0] ins, input logic [3:0] ty,
                       input logic [63:0] e_imm, input logic e_ill);
    int   n;
    bit   got;
    exp_t e;
    n   = 0;
    got = 1'b0;
    instr    = ins;
    imm_type = ty;
    set_valid(sel, 1'b1);
    while (!got && n < 20) begin
      @(negedge clk);
      if (rdy(sel)) got = 1'b1;
      else n++;
    end
    if (!got) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout dut%0d ready_out stayed 0, required 1", sel);
    end else begin
      e.imm = e_imm;
      e.ill = e_ill;
      if (sel == 0) q0.push_back(e);
      else if (sel == 1) q1.push_back(e);
      else q2.push_back(e);
    end
    @(posedge clk);
    #1;
    set_valid(sel, 1'b0);
  endtask

  task automatic drain_wait(input int sel);
    int n;
    n = 0;
    while (qsize(sel) > 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    #1;
    cmp($sformatf("drain_dut%0d_pending", sel), 64'(qsize(sel)), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; ready_in = 1'b1;
    instr = '0; imm_type = '0;
    vin0 = 1'b0; vin1 = 1'b0; vin2 = 1'b0;

    repeat (2) @(negedge clk);
    cmp("reset_valid_out", {63'h0, vo0}, 64'd0);
    cmp("reset_ready_out", {63'h0, ro0}, 64'd1);
    cmp("reset_imm_out", {32'h0, imm0}, 64'd0);
    cmp("reset_illegal_out", {63'h0, ill0}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // XLEN=32 directed vectors, back-to-back with ready_in=1
    issue(0, 32'hFFF00093, 4'd0,  64'h00000000FFFFFFFF, 1'b0);
    issue(0, 32'hFE000EE3, 4'd3,  64'h00000000FFFFFFFC, 1'b0);
    issue(0, 32'h0000A009, 4'd10, 64'h0000000000000002, 1'b0);
    issue(0, 32'h0000557D, 4'd8,  64'h00000000FFFFFFFF, 1'b0);
    issue(0, 32'hFE112E23, 4'd2,  64'h00000000FFFFFFFC, 1'b0);
    issue(0, 32'h008000EF, 4'd5,  64'h0000000000000008, 1'b0);
    issue(0, 32'h00001460, 4'd9,  64'h000000000000006C, 1'b0);
    issue(0, 32'h00000004, 4'd11, 64'h0000000000000020, 1'b0);
    issue(0, 32'h00001000, 4'd11, 64'h00000000FFFFFF00, 1'b0);
    issue(0, 32'h7FF00013, 4'd7,  64'h00000000000007FF, 1'b0);
    issue(0, 32'hFFF00093, 4'd13, 64'h00000000FFFFFFFF, 1'b1);
    drain_wait(0);

    // XLEN=64
    issue(1, 32'h800000B7, 4'd4, 64'hFFFFFFFF80000000, 1'b0);
    issue(1, 32'h000F8073, 4'd6, 64'h000000000000001F, 1'b0);
    issue(1, 32'h80000013, 4'd1, 64'hFFFFFFFFFFFFF800, 1'b0);
    issue(1, 32'h00001460, 4'd9, 64'h000000000000006C, 1'b0);
    drain_wait(1);

    // RVC disabled: compressed types fall back to I-type and flag illegal
    issue(2, 32'h0000557D, 4'd8,  64'h0000000000000000, 1'b1);
    issue(2, 32'hFFF0A009, 4'd10, 64'h00000000FFFFFFFF, 1'b1);
    issue(2, 32'h00100093, 4'd0,  64'h0000000000000001, 1'b0);
    drain_wait(2);

    // Back-pressure: A and B fill the buffer, C waits upstream
    ready_in = 1'b0;
    issue(0, 32'h12300093, 4'd0, 64'h0000000000000123, 1'b0);
    issue(0, 32'h45600093, 4'd0, 64'h0000000000000456, 1'b0);
    instr = 32'h78900093; imm_type = 4'd0; vin0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cmp($sformatf("stall%0d_ready_out", i), {63'h0, ro0}, 64'd0);
      cmp($sformatf("stall%0d_valid_out", i), {63'h0, vo0}, 64'd1);
      cmp($sformatf("stall%0d_imm_hold", i), {32'h0, imm0}, 64'h123);
    end
    @(posedge clk); #1;
    ready_in = 1'b1;
    issue(0, 32'h78900093, 4'd0, 64'h0000000000000789, 1'b0);
    drain_wait(0);

    // Flush while in TWO with a new entry offered
    ready_in = 1'b0;
    issue(0, 32'h11100093, 4'd0, 64'h0000000000000111, 1'b0);
    issue(0, 32'h22200093, 4'd0, 64'h0000000000000222, 1'b0);
    instr = 32'h33300093; imm_type = 4'd0; vin0 = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; vin0 = 1'b0;
    q0.delete();
    @(negedge clk);
    cmp("flush_valid_out", {63'h0, vo0}, 64'd0);
    cmp("flush_ready_out", {63'h0, ro0}, 64'd1);
    @(negedge clk);
    cmp("flush_entry_dropped", {63'h0, vo0}, 64'd0);
    ready_in = 1'b1;
    @(posedge clk); #1;

    // Asynchronous reset in the middle of a stall
    ready_in = 1'b0;
    issue(0, 32'hFFF00093, 4'd13, 64'h00000000FFFFFFFF, 1'b1);
    issue(0, 32'h55500093, 4'd0,  64'h0000000000000555, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    cmp("areset_valid_out", {63'h0, vo0}, 64'd0);
    cmp("areset_imm_out", {32'h0, imm0}, 64'd0);
    cmp("areset_illegal_out", {63'h0, ill0}, 64'd0);
    cmp("areset_ready_out", {63'h0, ro0}, 64'd1);
    q0.delete();
    @(negedge clk);
    rst_n = 1'b1;
    ready_in = 1'b1;
    @(posedge clk); #1;

    // Pipe still works after reset
    issue(0, 32'h0000A009, 4'd10, 64'h0000000000000002, 1'b0);
    drain_wait(0);
    repeat (2) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/msrv32_imm_gen_pipe.md
Name: msrv32_imm_gen_pipe

Overview:
Registered, parametrised successor to the combinational immediate generator. It sits between the decoder and the execute stage. It produces XLEN-wide immediates for the RV32/RV64 base formats and for the RVC compressed formats, flags illegal immediate types, and carries a valid/ready handshake with a 2-entry skid buffer so that execute-stage back-pressure never creates a combinational path back into decode.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64; every immediate is sign- or zero-extended to XLEN.
RVC_EN, 1, 1 enables compressed types 8-11; 0 treats types 8-11 as illegal.

Ports:
clk_in  input  1  clock, rising edge
rst_n_in  input  1  asynchronous active-low reset
flush_in  input  1  synchronous clear of all buffered entries
valid_in  input  1  upstream entry valid
ready_out  output  1  entry can be accepted
instr_in  input  32  raw instruction; RVC types use bits [15:0]
imm_type_in  input  4  immediate type select
valid_out  output  1  imm_out/illegal_out valid
ready_in  input  1  downstream accepts
imm_out  output  XLEN  generated immediate
illegal_out  output  1  imm_type_in was illegal for this entry

Behaviour:
- Reset (rst_n_in low, asynchronous): buffer goes to EMPTY; valid_out=0, ready_out=1, imm_out=0, illegal_out=0, skid contents=0.
- Type encoding, with sext = sign-extend to XLEN:
  - 0, 1, 7 I: sext(instr[31:20]).
  - 2 S: sext({instr[31:25], instr[11:7]}).
  - 3 B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
  - 4 U: sext({instr[31:12], 12'h0}); upper bits are 1s when XLEN=64 and instr[31]=1.
  - 5 J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
  - 6 CSR: zero-extend instr[19:15].
  - 8 CI: sext({instr[12], instr[6:2]}).
  - 9 CL/CS word: zero-extend {instr[5], instr[12:10], instr[6], 2'b00}.
  - 10 CJ: sext of offset[11:1] with offset[11|4|9:8|10|6|7|3:1|5] = instr[12|11|10:9|8|7|6|5:3|2], bit0=0.
  - 11 CB: sext of offset[8:1] with offset[8|4:3|7:6|2:1|5] = instr[12|11:10|6:5|4:3|2], bit0=0.
  - 12-15, or 8-11 with RVC_EN=0: imm = I-type value, illegal_out=1.
- Computation is combinational on instr_in and imm_type_in. The result is captured on acceptance (valid_in & ready_out). Latency is 1 cycle: the entry is presented on valid_out on the next edge.
- Buffer FSM: EMPTY, ONE (output register full), TWO (output register plus skid full).
  - EMPTY: accept -> ONE.
  - ONE:
    - accept and no drain -> TWO; the new entry goes to skid.
    - accept and drain -> ONE; the output register is reloaded with the new entry.
    - drain only -> EMPTY.
    - neither -> ONE.
  - TWO: drain -> ONE; skid moves to the output register. No accept is possible in TWO.
  - drain = valid_out & ready_in.
- ready_out = (state != TWO). It is registered/derived from state only and has no combinational path from ready_in.
- Ordering: strictly FIFO. imm_out/illegal_out hold stable while valid_out=1 and ready_in=0.
- flush_in=1 at an edge: state -> EMPTY and valid_out=0 on the next cycle, regardless of simultaneous accept or drain (flush wins). imm_out data values need not clear.
- Reset mid-operation discards all entries immediately.

Decomposition:
- Shared package msrv32_pkg:
  - imm type localparams: IMM_I=0, IMM_I_ALT=1, IMM_S=2, IMM_B=3, IMM_U=4, IMM_J=5, IMM_CSR=6, IMM_I2=7, IMM_CI=8, IMM_CLS=9, IMM_CJ=10, IMM_CB=11.
  - FSM state encodings.
- Sub-module msrv32_imm_decode_comb (pure combinational: instr, type -> imm, illegal) instantiated once. The top level holds the skid/FSM.

Test Plan:
- XLEN=32, instr 0xFFF00093 type 0, ready_in=1 -> next cycle valid_out=1, imm_out 0xFFFFFFFF, illegal_out=0.
- Type 3, instr 0xFE000EE3 -> imm_out 0xFFFFFFFC. Type 10, instr 0x0000A009 -> 0x00000002. Type 8, instr 0x0000557D -> 0xFFFFFFFF.
- XLEN=64, type 4, instr 0x800000B7 -> imm_out 0xFFFFFFFF80000000. Type 6, instr 0x000F8073 -> 0x000000000000001F.
- Back-pressure:
  - Stimulus: stream entries A, B, C with valid_in=1; hold ready_in=0 for 3 cycles.
  - Check: A and B accepted, then ready_out=0 with C held upstream.
  - Release ready_in: outputs A, B, C in order with no loss or duplication; imm_out stable while stalled.
- Illegal types:
  - Type 13, instr 0xFFF00093 -> illegal_out=1, imm_out 0xFFFFFFFF.
  - RVC_EN=0, type 8 -> illegal_out=1.
- Flush and reset:
  - In state TWO, assert flush_in together with valid_in=1 -> next cycle valid_out=0, ready_out=1, new entry dropped.
  - Pulse rst_n_in low asynchronously mid-stall -> valid_out=0 and imm_out=0 immediately.
